axil_to_simple_bridge: RTL and testbench

//  AXI4-Lite slave to "simple" bus master bridge; sits directly upstream of the simulation memory model.

---
 rtl/axil_to_simple_bridge.sv | 169 ++++++++++++++++
 tb/tb_axil_to_simple_bridge.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_to_simple_bridge.sv
// AXI4-Lite slave to simple-bus master bridge with one outstanding transaction.
// AW/W/AR beats are held independently, arbitrated, and serialised onto the simple bus.
module axil_to_simple_bridge #(
   parameter int ADDR_W       = 32,
   parameter bit BAD_STRB_ERR = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_wvalid,
   output logic              s_wready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   output logic              s_bvalid,
   input  logic              s_bready,
   output logic [1:0]        s_bresp,
   input  logic              s_arvalid,
   output logic              s_arready,
   input  logic [ADDR_W-1:0] s_araddr,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [31:0]       s_rdata,
   output logic [1:0]       s_rresp,
   output logic              simple_out_valid,
   input  logic              simple_out_ready,
   output logic [ADDR_W-1:0] simple_out_bits_addr,
   output logic              simple_out_bits_writeEn,
   output logic [2:0]        simple_out_bits_size,
   output logic [31:0]       simple_out_bits_wdata,
   input  logic [31:0]       simple_in_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} state_t;

   state_t              state, state_nx;
   logic                aw_full, w_full, ar_full;
   logic [ADDR_W-1:2]   aw_addr, ar_addr;
   logic [31:0]         w_data;
   logic [3:0]          w_strb;
   logic                cur_wr, last_rd;
   logic [1:0]          bresp;
   logic [31:0]         rdata;

   logic                dec_bad;
   logic [2:0]          dec_size;
   logic [1:0]          dec_off;
   logic [31:0]         dec_data;
   logic                wr_elig, rd_elig, grant_wr, strb_err, resp_hs;
   logic                unused_addr_lsbs;

   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

   // Ready outputs are forced low while reset is held so every output reads 0 during reset.
   assign s_awready = reset & ~aw_full;
   assign s_wready  = reset & ~w_full;
   assign s_arready = reset & ~ar_full;

   always_comb begin
      dec_bad  = 1'b0;
      dec_size = 3'd2;
      dec_off  = 2'd0;
      dec_data = w_data;
      case (w_strb)
         4'b0001: begin dec_size = 3'd0; dec_data = {24'd0, w_data[7:0]}; end
         4'b0010: begin dec_size = 3'd0; dec_off = 2'd1; dec_data = {24'd0, w_data[15:8]}; end
         4'b0100: begin dec_size = 3'd0; dec_off = 2'd2; dec_data = {24'd0, w_data[23:16]}; end
         4'b1000: begin dec_size = 3'd0; dec_off = 2'd3; dec_data = {24'd0, w_data[31:24]}; end
         4'b0011: begin dec_size = 3'd1; dec_data = {16'd0, w_data[15:0]}; end
         4'b1100: begin dec_size = 3'd1; dec_off = 2'd2; dec_data = {16'd0, w_data[31:16]}; end
         4'b1111: dec_size = 3'd2;
         default: dec_bad = 1'b1;
      endcase
   end

   assign wr_elig  = aw_full & w_full;
   assign rd_elig  = ar_full;
   assign grant_wr = wr_elig & (~rd_elig | last_rd);
   assign strb_err = dec_bad & BAD_STRB_ERR;
   assign resp_hs  = (state == RESP) & (cur_wr ? s_bready : s_rready);

   always_comb begin
      state_nx                = state;
      simple_out_valid        = 1'b0;
      simple_out_bits_addr    = '0;
      simple_out_bits_writeEn = 1'b0;
      simple_out_bits_size    = '0;
      simple_out_bits_wdata   = '0;
      case (state)
         IDLE: begin
            if (grant_wr)     state_nx = strb_err ? RESP : REQ;
            else if (rd_elig) state_nx = REQ;
         end
         REQ: begin
            simple_out_valid = 1'b1;
            if (cur_wr) begin
               simple_out_bits_addr    = {aw_addr, dec_off};
               simple_out_bits_writeEn = 1'b1;
               simple_out_bits_size    = dec_size;
               simple_out_bits_wdata   = dec_data;
            end else begin
               simple_out_bits_addr = {ar_addr, 2'b00};
               simple_out_bits_size = 3'd2;
            end
            if (simple_out_ready) state_nx = cur_wr ? RESP : RDWAIT;
         end
         RDWAIT: state_nx = RESP;
         RESP: if (resp_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         ar_full <= 1'b0;
         aw_addr <= '0;
         ar_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         cur_wr  <= 1'b0;
         last_rd <= 1'b0;
         bresp   <= '0;
         rdata   <= '0;
      end else begin
         if (s_awvalid && s_awready) begin
            aw_full <= 1'b1;
            aw_addr <= s_awaddr[ADDR_W-1:2];
         end else if (resp_hs && cur_wr) begin
            aw_full <= 1'b0;
         end
         if (s_wvalid && s_wready) begin
            w_full <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
         end else if (resp_hs && cur_wr) begin
            w_full <= 1'b0;
         end
         if (s_arvalid && s_arready) begin
            ar_full <= 1'b1;
            ar_addr <= s_araddr[ADDR_W-1:2];
         end else if (resp_hs && !cur_wr) begin
            ar_full <= 1'b0;
         end
         if (state == IDLE && (wr_elig || rd_elig)) begin
            cur_wr  <= grant_wr;
            last_rd <= ~grant_wr;
            bresp   <= (grant_wr && strb_err) ? 2'b10 : 2'b00;
         end else if (resp_hs && cur_wr) begin
            bresp <= '0;
         end
         if (state == RDWAIT) rdata <= simple_in_rdata;
      end
   end

   assign s_bvalid = (state == RESP) & cur_wr;
   assign s_rvalid = (state == RESP) & ~cur_wr;
   assign s_bresp  = bresp;
   assign s_rdata  = rdata;
   assign s_rresp  = '0;

endmodule

// File: tb/tb_axil_to_simple_bridge.sv
// Scoreboard bench for axil_to_simple_bridge: stimulus pushes expectations from a byte-level
// reference model, independent monitors pop and compare bus requests and B/R responses.
module tb_axil_to_simple_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        s_awvalid = 1'b0, s_awready;
   logic [31:0] s_awaddr = '0;
   logic        s_wvalid = 1'b0, s_wready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_bvalid, s_bready = 1'b1;
   logic [1:0]  s_bresp;
   logic        s_arvalid = 1'b0, s_arready;
   logic [31:0] s_araddr = '0;
   logic        s_rvalid, s_rready = 1'b1;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        simple_out_valid, simple_out_ready = 1'b1;
   logic [31:0] simple_out_bits_addr;
   logic        simple_out_bits_writeEn;
   logic [2:0]  simple_out_bits_size;
   logic [31:0] simple_out_bits_wdata;
   logic [31:0] simple_in_rdata = '0;

   axil_to_simple_bridge #(.ADDR_W(32), .BAD_STRB_ERR(1'b1)) dut (
      .clock(clock), .reset(reset),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .simple_out_valid(simple_out_valid), .simple_out_ready(simple_out_ready),
      .simple_out_bits_addr(simple_out_bits_addr),
      .simple_out_bits_writeEn(simple_out_bits_writeEn),
      .simple_out_bits_size(simple_out_bits_size),
      .simple_out_bits_wdata(simple_out_bits_wdata),
      .simple_in_rdata(simple_in_rdata)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [2:0]  size;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [1:0]  bq[$];
   logic [31:0] rq[$];
   bit [7:0]    bus_mem[bit [31:0]];
   bit [7:0]    ref_mem[bit [31:0]];

   int   cyc = 0;
   int   total = 0, passed = 0;
   int   b_rise = 0, r_rise = 0;
   int   bus_stall = 0, r_stall = 0;
   bit   rnd_rdy = 1'b0;
   bit   last_rd_m = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      total++;
      $display("FAIL %s: event seen/missed, required the opposite", name);
   endtask

   function automatic bit [7:0] ref_rd(input bit [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic bit [7:0] bus_rd(input bit [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
   endfunction

   // Reference model: strobe legality and lane extraction from popcount / lowest-set-lane arithmetic.
   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int   n, k;
      bit   good;
      req_t e;
      n = $countones(s);
      k = 0;
      while (k < 3 && s[k] == 1'b0) k++;
      good = (n == 1) || (n == 2 && (k == 0 || k == 2) && s == (4'b0011 << k)) || (s == 4'hF);
      last_rd_m = 1'b0;
      if (!good) begin
         bq.push_back(2'b10);
      end else begin
         e.addr  = {a[31:2], 2'b00} + k;
         e.we    = 1'b1;
         e.size  = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
         e.wdata = (d >> (8 * k)) & ((n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1));
         for (int i = 0; i < n; i++) ref_mem[e.addr + i] = e.wdata[8*i +: 8];
         req_q.push_back(e);
         bq.push_back(2'b00);
      end
   endtask

   task automatic model_read(input logic [31:0] a);
      req_t        e;
      logic [31:0] al;
      al = a & 32'hFFFF_FFFC;
      last_rd_m = 1'b1;
      e.addr = al; e.we = 1'b0; e.size = 3'd2; e.wdata = '0;
      req_q.push_back(e);
      rq.push_back({ref_rd(al + 3), ref_rd(al + 2), ref_rd(al + 1), ref_rd(al)});
   endtask

   // Simple-bus memory: returns read data exactly one cycle after an accepted read, noise otherwise.
   initial begin
      forever begin
         logic        hs, we;
         logic [31:0] ad, wd;
         logic [2:0]  sz;
         @(posedge clock);
         hs = reset && simple_out_valid && simple_out_ready;
         we = simple_out_bits_writeEn; ad = simple_out_bits_addr;
         wd = simple_out_bits_wdata;   sz = simple_out_bits_size;
         if (hs && we) for (int i = 0; i < (1 << sz); i++) bus_mem[ad + i] = wd[8*i +: 8];
         #1;
         if (hs && !we) simple_in_rdata = {bus_rd(ad + 3), bus_rd(ad + 2), bus_rd(ad + 1), bus_rd(ad)};
         else           simple_in_rdata = $urandom;
      end
   end

   initial begin
      forever begin
         @(posedge clock); #1;
         if (bus_stall > 0) begin
            simple_out_ready = 1'b0;
            if (simple_out_valid) bus_stall--;
         end else simple_out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (r_stall > 0) begin
            s_rready = 1'b0;
            if (s_rvalid) r_stall--;
         end else s_rready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_bready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   req_t        mon_e, mon_prev;
   bit          mon_pv = 1'b0;
   always @(negedge clock) begin
      if (!reset) mon_pv = 1'b0;
      else begin
         if (mon_pv) begin
            check("req_valid_held", simple_out_valid, 1'b1);
            check("req_fields_held", {simple_out_bits_addr, simple_out_bits_writeEn,
                  simple_out_bits_size, simple_out_bits_wdata}, mon_prev);
         end
         if (simple_out_valid && simple_out_ready) begin
            if (req_q.size() == 0) fail("req_unexpected");
            else begin
               mon_e = req_q.pop_front();
               check("req_addr", simple_out_bits_addr, mon_e.addr);
               check("req_we", simple_out_bits_writeEn, mon_e.we);
               check("req_size", simple_out_bits_size, mon_e.size);
               if (mon_e.we) check("req_wdata", simple_out_bits_wdata, mon_e.wdata);
            end
         end
         mon_pv   = simple_out_valid && !simple_out_ready;
         mon_prev = {simple_out_bits_addr, simple_out_bits_writeEn, simple_out_bits_size,
                     simple_out_bits_wdata};
      end
   end

   bit          pb_v = 1'b0, pr_v = 1'b0, pb_hold = 1'b0, pr_hold = 1'b0;
   logic [1:0]  pb_resp;
   logic [31:0] pr_data, exp_r;
   logic [1:0]  exp_b;
   always @(negedge clock) begin
      if (!reset) begin
         pb_v = 1'b0; pr_v = 1'b0; pb_hold = 1'b0; pr_hold = 1'b0;
      end else begin
         if (s_bvalid && !pb_v) b_rise = cyc;
         if (s_rvalid && !pr_v) r_rise = cyc;
         if (pb_hold) check("b_held", {s_bvalid, s_bresp}, {1'b1, pb_resp});
         if (pr_hold) check("r_held", {s_rvalid, s_rdata}, {1'b1, pr_data});
         if (s_rvalid) check("arready_low_during_r", s_arready, 1'b0);
         if (s_bvalid && s_bready) begin
            if (bq.size() == 0) fail("b_unexpected");
            else begin
               exp_b = bq.pop_front();
               check("bresp", s_bresp, exp_b);
            end
         end
         if (s_rvalid && s_rready) begin
            if (rq.size() == 0) fail("r_unexpected");
            else begin
               exp_r = rq.pop_front();
               check("rdata", s_rdata, exp_r);
               check("rresp", s_rresp, 2'b00);
            end
         end
         pb_v = s_bvalid; pr_v = s_rvalid;
         pb_hold = s_bvalid && !s_bready; pb_resp = s_bresp;
         pr_hold = s_rvalid && !s_rready; pr_data = s_rdata;
      end
   end

   task automatic send_aw(input logic [31:0] a, output int hc);
      int n = 0;
      hc = 0;
      s_awaddr = a; s_awvalid = 1'b1;
      forever begin
         @(negedge clock);
         if (s_awready) begin hc = cyc; break; end
         n++;
         if (n > 300) begin fail("aw_handshake_timeout"); break; end
      end
      @(posedge clock); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hc);
      int n = 0;
      hc = 0;
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
      forever begin
         @(negedge clock);
         if (s_wready) begin hc = cyc; break; end
         n++;
         if (n > 300) begin fail("w_handshake_timeout"); break; end
      end
      @(posedge clock); #1;
      s_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, output int hc);
      int n = 0;
      hc = 0;
      s_araddr = a; s_arvalid = 1'b1;
      forever begin
         @(negedge clock);
         if (s_arready) begin hc = cyc; break; end
         n++;
         if (n > 300) begin fail("ar_handshake_timeout"); break; end
      end
      @(posedge clock); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((req_q.size() != 0 || bq.size() != 0 || rq.size() != 0) && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (n >= 400) begin
         fail(name);
         req_q.delete(); bq.delete(); rq.delete();
      end
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit chk_lat);
      int ha, hw;
      model_write(a, d, s);
      fork
         begin repeat (aw_dly) begin @(posedge clock); #1; end send_aw(a, ha); end
         begin repeat (w_dly) begin @(posedge clock); #1; end send_w(d, s, hw); end
      join
      wait_idle("write_done_timeout");
      if (chk_lat) check("write_latency", b_rise - ((ha > hw) ? ha : hw), 3);
   endtask

   task automatic do_read(input logic [31:0] a, input bit chk_lat);
      int hr;
      model_read(a);
      send_ar(a, hr);
      wait_idle("read_done_timeout");
      if (chk_lat) check("read_latency", r_rise - hr, 4);
   endtask

   // Both channels eligible together: grant goes opposite to the previous grant.
   task automatic do_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] ra);
      int h1, h2, h3;
      if (last_rd_m) begin model_write(wa, wd, ws); model_read(ra); end
      else           begin model_read(ra); model_write(wa, wd, ws); end
      fork
         send_aw(wa, h1);
         send_w(wd, ws, h2);
         send_ar(ra, h3);
      join
      wait_idle("pair_done_timeout");
   endtask

   function automatic logic [31:0] rnd_addr();
      return 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
   endfunction

   logic [3:0] strbs [8];
   int         hr_abort, rv_cnt;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      strbs = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0};
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
            s_rdata, simple_out_valid, simple_out_bits_writeEn, simple_out_bits_size,
            simple_out_bits_addr, simple_out_bits_wdata}, '0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("ready_after_reset", {s_awready, s_wready, s_arready}, 3'b111);
      @(posedge clock); #1;

      do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1);
      do_write(32'h8000_0000, 32'h0000_AB00, 4'h2, 0, 0, 1'b1);
      do_read(32'h8000_0000, 1'b1);
      do_write(32'h8000_0010, 32'h1234_5678, 4'h5, 5, 0, 1'b0);
      do_write(32'h8000_0014, 32'hCAFE_F00D, 4'hC, 5, 0, 1'b1);
      do_read(32'h8000_0014, 1'b0);
      do_pair(32'h8000_0020, 32'h1111_2222, 4'hF, 32'h8000_0004);
      do_pair(32'h8000_0024, 32'h3333_4444, 4'h3, 32'h8000_0020);

      bus_stall = 4;
      r_stall   = 3;
      do_read(32'h8000_0024, 1'b0);
      check("bus_stall_consumed", bus_stall, 0);
      check("r_stall_consumed", r_stall, 0);

      // Abort in the wait-for-rdata cycle: the request goes out, no response must follow.
      begin
         req_t e;
         e.addr = 32'h8000_0004; e.we = 1'b0; e.size = 3'd2; e.wdata = '0;
         req_q.push_back(e);
         send_ar(32'h8000_0007, hr_abort);
         @(posedge clock);
         @(posedge clock); #1;
         reset = 1'b0;
         last_rd_m = 1'b0;
         @(negedge clock);
         check("abort_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp,
               s_rresp, s_rdata, simple_out_valid, simple_out_bits_writeEn, simple_out_bits_size,
               simple_out_bits_addr, simple_out_bits_wdata}, '0);
         repeat (2) @(posedge clock);
         #1 reset = 1'b1;
         rv_cnt = 0;
         repeat (10) begin
            @(negedge clock);
            if (s_rvalid) rv_cnt++;
         end
         check("no_r_after_abort", rv_cnt, 0);
         check("abort_req_issued", req_q.size(), 0);
         @(posedge clock); #1;
      end
      do_read(32'h8000_0004, 1'b1);
      do_pair(32'h8000_0030, 32'h5555_6666, 4'h1, 32'h8000_0030);

      rnd_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int          kind;
         logic [3:0]  s;
         logic [31:0] a, d;
         kind = $urandom_range(0, 2);
         a = rnd_addr();
         d = $urandom;
         s = strbs[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) bus_stall = $urandom_range(1, 5);
         if ($urandom_range(0, 5) == 0) r_stall = $urandom_range(1, 4);
         case (kind)
            0:       do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            1:       do_read(a, 1'b0);
            default: do_pair(a, d, s, rnd_addr());
         endcase
      end

      repeat (5) @(posedge clock);
      check("queues_drained", req_q.size() + bq.size() + rq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
